keycode_event_queue: RTL and testbench

- Consumes the 8-bit USB keycode that the Nios II firmware writes to the keycode PIO output of the SoC.
- Turns level changes into timestamp-free key events: press, release, and optional typematic repeat.
- Buffers the events in a small FIFO for the game/graphics logic, which pops them with a valid/ready handshake.
- Sits in the top level, directly downstream of the SoC keycode export.

---
 rtl/keycode_event_queue.sv | 190 +++++++++++++++++++
 tb/tb_keycode_event_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/keycode_event_queue.sv
// keycode_event_queue: turns keycode level changes from the SoC PIO into
// press / release (and optional typematic repeat) events, buffered in a
// show-ahead FIFO popped with a valid/ready handshake.
// Optional feature macro: KEY_REPEAT_EN (repeat counter and REPEAT events).
module keycode_event_queue #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset_n,
   input  logic [7:0]                   keycode_in,
   output logic                         ev_valid,
   output logic [7:0]                   ev_code,
   output logic [1:0]                   ev_type,
   input  logic                         ev_ready,
   output logic [$clog2(DEPTH+1)-1:0]   ev_count,
   output logic                         overflow,
   input  logic                         overflow_clr
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      HELD       = 2'd1,
      PRESS_PEND = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      EV_PRESS   = 2'b00,
      EV_RELEASE = 2'b01,
      EV_REPEAT  = 2'b10
   } ev_t;

   state_t           state_q, state_d;
   logic [7:0]       held_q, held_d;
   logic [7:0]       pend_q, pend_d;

   logic             push;
   logic [7:0]       push_code;
   logic [1:0]       push_type;

   logic [7:0]       code_q [DEPTH];
   logic [1:0]       type_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   logic             full, pop, accept, drop;

`ifdef KEY_REPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX);

   logic [RPT_W-1:0] rpt_q, rpt_d;

   // Repeat countdown register.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) rpt_q <= '0;
      else                rpt_q <= rpt_d;
   end
`else
   // Repeat timing parameters only matter with the repeat feature built in.
   if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_repeat_params_unused
   end
`endif

   // Key tracking FSM state registers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q <= IDLE;
         held_q  <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic and event generation; FSM advances even if the push is dropped.
   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      pend_d    = pend_q;
      push      = 1'b0;
      push_code = '0;
      push_type = EV_PRESS;
`ifdef KEY_REPEAT_EN
      rpt_d     = rpt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (keycode_in != 8'h00) begin
               push      = 1'b1;
               push_code = keycode_in;
               push_type = EV_PRESS;
               held_d    = keycode_in;
               state_d   = HELD;
`ifdef KEY_REPEAT_EN
               rpt_d     = RPT_W'(REPEAT_DELAY - 1);
`endif
            end
         end
         HELD: begin
            if (keycode_in == held_q) begin
`ifdef KEY_REPEAT_EN
               if (rpt_q == '0) begin
                  push      = 1'b1;
                  push_code = held_q;
                  push_type = EV_REPEAT;
                  rpt_d     = RPT_W'(REPEAT_RATE - 1);
               end else begin
                  rpt_d     = rpt_q - 1'b1;
               end
`endif
            end else begin
               push      = 1'b1;
               push_code = held_q;
               push_type = EV_RELEASE;
               if (keycode_in == 8'h00) begin
                  held_d  = '0;
                  state_d = IDLE;
               end else begin
                  pend_d  = keycode_in;
                  state_d = PRESS_PEND;
               end
            end
         end
         PRESS_PEND: begin
            push      = 1'b1;
            push_code = pend_q;
            push_type = EV_PRESS;
            held_d    = pend_q;
            state_d   = HELD;
`ifdef KEY_REPEAT_EN
            rpt_d     = RPT_W'(REPEAT_DELAY - 1);
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign full   = (count_q == CNT_W'(DEPTH));
   assign pop    = ev_valid && ev_ready;
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   // Occupancy and sticky overflow; a drop wins over a same-cycle clear.
   always_comb begin
      count_d = count_q;
      if (accept && !pop)      count_d = count_q + CNT_W'(1);
      else if (!accept && pop) count_d = count_q - CNT_W'(1);
      ovf_d = ovf_q;
      if (drop)              ovf_d = 1'b1;
      else if (overflow_clr) ovf_d = 1'b0;
   end

   // FIFO storage, pointers and counters.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            code_q[i] <= '0;
            type_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            code_q[wptr_q] <= push_code;
            type_q[wptr_q] <= push_type;
            wptr_q         <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ev_valid = (count_q != '0);
   assign ev_code  = ev_valid ? code_q[rptr_q] : '0;
   assign ev_type  = ev_valid ? type_q[rptr_q] : '0;
   assign ev_count = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Scoreboard bench for keycode_event_queue (DEPTH=4, REPEAT_DELAY=10, REPEAT_RATE=4).
module tb_keycode_event_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] keycode;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic [1:0] ev_type;
   logic       ev_ready;
   logic [2:0] ev_count;
   logic       overflow;
   logic       overflow_clr;

   int errors = 0;
   int checks = 0;
   logic [9:0] exp_q[$];

   keycode_event_queue #(
      .DEPTH(4),
      .REPEAT_DELAY(10),
      .REPEAT_RATE(4)
   ) dut (
      .clk_clk(clk),
      .reset_reset_n(rst_n),
      .keycode_in(keycode),
      .ev_valid(ev_valid),
      .ev_code(ev_code),
      .ev_type(ev_type),
      .ev_ready(ev_ready),
      .ev_count(ev_count),
      .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic expect_ev(input logic [7:0] code, input logic [1:0] typ);
      exp_q.push_back({code, typ});
   endtask

   // Monitor: every handshake pops the scoreboard and compares the head event.
   always @(negedge clk) begin
      if (rst_n && ev_valid && ev_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got code=%02h type=%b, none expected", ev_code, ev_type);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if ({ev_code, ev_type} !== e) begin
               errors++;
               $display("FAIL event_order: got code=%02h type=%b expected code=%02h type=%b",
                        ev_code, ev_type, e[9:2], e[1:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; keycode = 8'h00; ev_ready = 1'b1; overflow_clr = 1'b0;
      step(2);
      check("reset_valid", 32'(ev_valid), 0);
      check("reset_count", 32'(ev_count), 0);
      check("reset_overflow", 32'(overflow), 0);
      check("reset_code_type", 32'({ev_code, ev_type}), 0);
      rst_n = 1'b1;
      step(1);

      // Single press, then hold: one event only.
      keycode = 8'h04; expect_ev(8'h04, 2'b00);
      step(1);
      check("press_visible", 32'({ev_valid, ev_code, ev_type}), 32'({1'b1, 8'h04, 2'b00}));
      step(3);
      check("press_drained", 32'(ev_count), 0);

      // Direct key-to-key change, then release.
      keycode = 8'h16; expect_ev(8'h04, 2'b01); expect_ev(8'h16, 2'b00);
      step(1);
      check("change_release_first", 32'({ev_code, ev_type}), 32'({8'h04, 2'b01}));
      step(1);
      keycode = 8'h00; expect_ev(8'h16, 2'b01);
      step(3);
      check("release_drained", 32'(ev_count), 0);

`ifdef KEY_REPEAT_EN
      // Typematic repeat: press at E, repeats at E+10, E+14, E+18.
      keycode = 8'h1A; expect_ev(8'h1A, 2'b00);
      expect_ev(8'h1A, 2'b10); expect_ev(8'h1A, 2'b10); expect_ev(8'h1A, 2'b10);
      step(1);
      step(9);
      check("no_repeat_before_delay", 32'(ev_valid), 0);
      step(1);
      check("first_repeat", 32'({ev_valid, ev_code, ev_type}), 32'({1'b1, 8'h1A, 2'b10}));
      step(3);
      check("no_repeat_before_rate", 32'(ev_valid), 0);
      step(1);
      check("second_repeat", 32'({ev_valid, ev_type}), 32'({1'b1, 2'b10}));
      step(4);
      keycode = 8'h00; expect_ev(8'h1A, 2'b01);
      step(1);
      check("repeat_release", 32'({ev_valid, ev_code, ev_type}), 32'({1'b1, 8'h1A, 2'b01}));
      step(2);
`endif

      // Overflow: six events with consumer stalled, only first four kept.
      ev_ready = 1'b0;
      keycode = 8'h05; expect_ev(8'h05, 2'b00); step(1);
      keycode = 8'h00; expect_ev(8'h05, 2'b01); step(1);
      keycode = 8'h06; expect_ev(8'h06, 2'b00); step(1);
      keycode = 8'h00; expect_ev(8'h06, 2'b01); step(1);
      check("no_overflow_at_full", 32'(overflow), 0);
      keycode = 8'h07; step(1);
      keycode = 8'h00; step(1);
      check("full_count", 32'(ev_count), 4);
      check("overflow_set", 32'(overflow), 1);
      overflow_clr = 1'b1; step(1); overflow_clr = 1'b0;
      check("overflow_cleared", 32'(overflow), 0);
      // Clear and drop on the same edge: drop wins.
      keycode = 8'h08; overflow_clr = 1'b1; step(1); overflow_clr = 1'b0;
      check("clear_vs_drop", 32'(overflow), 1);
      check("count_after_drop", 32'(ev_count), 4);
      overflow_clr = 1'b1; step(1); overflow_clr = 1'b0;
      check("overflow_recleared", 32'(overflow), 0);

      // Full FIFO with simultaneous pop and push: no drop.
      ev_ready = 1'b1; keycode = 8'h00; expect_ev(8'h08, 2'b01);
      step(1);
      check("push_pop_full_count", 32'(ev_count), 4);
      check("push_pop_full_overflow", 32'(overflow), 0);
      step(6);
      check("drained_after_full", 32'(ev_count), 0);

      // Reset mid-operation discards queue and the held key.
      ev_ready = 1'b0;
      keycode = 8'h09; step(1);
      keycode = 8'h00; step(1);
      keycode = 8'h04; step(1);
      check("queued_before_reset", 32'(ev_count), 3);
      rst_n = 1'b0; step(1);
      check("reset_mid_valid", 32'(ev_valid), 0);
      check("reset_mid_count", 32'(ev_count), 0);
      rst_n = 1'b1; ev_ready = 1'b1; expect_ev(8'h04, 2'b00);
      step(1);
      check("fresh_press_after_reset", 32'({ev_valid, ev_code, ev_type}), 32'({1'b1, 8'h04, 2'b00}));
      step(3);
      check("after_reset_drained", 32'(ev_count), 0);

      // Bounded wait for any outstanding expected events.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d events still expected, 0 required", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
